// File: rtl/pushbutton_conditioner.sv
// Pushbutton input conditioner: per-channel 2-flop synchroniser, consecutive-
// sample debouncer, registered press/release pulses and optional toggle latch.
module pushbutton_conditioner #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] buttons_raw,
  input  logic [WIDTH-1:0] toggle_en,
  output logic [WIDTH-1:0] buttons_clean,
  output logic [WIDTH-1:0] pressed_pulse,
  output logic [WIDTH-1:0] released_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] latch_q, latch_d;
  logic [WIDTH-1:0] pressed_q, pressed_d;
  logic [WIDTH-1:0] released_q, released_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Next-state: synchroniser shift, per-bit debounce counter, edge pulses, toggle latch
  always_comb begin
    sync1_d  = ACTIVE_LOW ? ~buttons_raw : buttons_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    pressed_d  = stable_d & ~stable_q;
    released_d = ~stable_d & stable_q;
    latch_d    = latch_q ^ (pressed_d & toggle_en);
  end

  // State registers with synchronous active-high reset taking priority
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      latch_q    <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      latch_q    <= latch_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Output select: toggle latch or debounced level, from registered state only
  always_comb begin
    buttons_clean  = (toggle_en & latch_q) | (~toggle_en & stable_q);
    pressed_pulse  = pressed_q;
    released_pulse = released_q;
  end

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Bench for pushbutton_conditioner: behavioural sample-history model checked
// every cycle against an active-high and an active-low instance, plus
// hand-computed literal expectations from the directed scenarios.
module tb_pushbutton_conditioner;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] raw   = 4'b1111;
  logic [3:0] tog   = 4'b0000;

  logic [3:0] clean_h, press_h, rel_h;
  logic [3:0] clean_l, press_l, rel_l;

  int checks   = 0;
  int failures = 0;

  pushbutton_conditioner #(
    .WIDTH(4), .DEBOUNCE_CYCLES(N), .CNT_W(8), .ACTIVE_LOW(1'b0)
  ) dut (
    .clock(clock), .reset(reset), .buttons_raw(raw), .toggle_en(tog),
    .buttons_clean(clean_h), .pressed_pulse(press_h), .released_pulse(rel_h)
  );

  pushbutton_conditioner #(
    .WIDTH(4), .DEBOUNCE_CYCLES(N), .CNT_W(8), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clock(clock), .reset(reset), .buttons_raw(~raw), .toggle_en(tog),
    .buttons_clean(clean_l), .pressed_pulse(press_l), .released_pulse(rel_l)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the debouncer sees the raw level from two edges earlier; a level is
  // adopted once N consecutive samples disagree with the current accepted level.
  logic [3:0] hist[$];
  logic [3:0] m_s = '0, m_l = '0, m_p = '0, m_r = '0;
  int         run[4];
  bit         model_valid = 1'b0;

  always @(posedge clock) begin
    logic [3:0] samp, ns;
    if (reset) begin
      hist.delete();
      m_s = '0; m_l = '0; m_p = '0; m_r = '0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      model_valid = 1'b1;
    end else begin
      hist.push_back(raw);
      if (hist.size() > 3) void'(hist.pop_front());
      samp = (hist.size() == 3) ? hist[0] : 4'b0000;
      ns = m_s;
      for (int i = 0; i < 4; i++) begin
        if (samp[i] != m_s[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == N) begin
            ns[i]  = samp[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_p = ns & ~m_s;
      m_r = m_s & ~ns;
      m_l = m_l ^ (m_p & tog);
      m_s = ns;
    end
  end

  bit count_b1 = 1'b0;
  int b1_pulses = 0;

  // Per-cycle comparison against the model, sampled on the falling edge
  always @(negedge clock) begin
    logic [3:0] m_clean;
    if (model_valid) begin
      m_clean = (tog & m_l) | (~tog & m_s);
      chk("model_clean_hi", clean_h, m_clean);
      chk("model_press_hi", press_h, m_p);
      chk("model_rel_hi",   rel_h,   m_r);
      chk("model_clean_lo", clean_l, m_clean);
      chk("model_press_lo", press_l, m_p);
      chk("model_rel_lo",   rel_l,   m_r);
      if (count_b1 && press_h[1]) b1_pulses++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    // 1: reset with all buttons held
    step(3);
    chk("t1_reset_clean", clean_h, 4'b0000);
    chk("t1_reset_press", press_h, 4'b0000);
    reset = 1'b0;
    step(5);
    chk("t1_e5_clean", clean_h, 4'b0000);
    step(1);
    chk("t1_e6_clean", clean_h, 4'b1111);
    chk("t1_e6_press", press_h, 4'b1111);
    step(1);
    chk("t1_e7_press", press_h, 4'b0000);
    chk("t1_e7_clean", clean_h, 4'b1111);
    raw = 4'b0000;
    step(6);
    chk("t1_rel", rel_h, 4'b1111);
    step(2);

    // 2: single press and release on bit 0
    raw = 4'b0001;
    step(5);
    chk("t2_e5_clean", clean_h, 4'b0000);
    step(1);
    chk("t2_e6_clean", clean_h, 4'b0001);
    chk("t2_e6_press", press_h, 4'b0001);
    step(1);
    chk("t2_e7_press", press_h, 4'b0000);
    raw = 4'b0000;
    step(6);
    chk("t2_rel", rel_h, 4'b0001);
    chk("t2_rel_clean", clean_h, 4'b0000);
    step(2);

    // 3: bouncing bit 1
    count_b1 = 1'b1;
    foreach (hist[i]) begin end
    for (int i = 0; i < 7; i++) begin
      logic [6:0] pat;
      pat = 7'b1101110;
      raw = {2'b00, pat[6 - i], 1'b0};
      step(1);
    end
    raw = 4'b0010;
    step(5);
    chk("t3_e5_clean", clean_h, 4'b0000);
    step(1);
    chk("t3_e6_clean", clean_h, 4'b0010);
    chk("t3_e6_press", press_h, 4'b0010);
    step(4);
    count_b1 = 1'b0;
    chk("t3_one_pulse", 4'(b1_pulses), 4'd1);
    raw = 4'b0000;
    step(8);

    // 4: toggle mode on bit 2
    tog = 4'b0100;
    raw = 4'b0100; step(6);
    chk("t4_press1_clean", clean_h, 4'b0100);
    raw = 4'b0000; step(6);
    chk("t4_rel1_pulse", rel_h, 4'b0100);
    chk("t4_rel1_clean", clean_h, 4'b0100);
    raw = 4'b0100; step(6);
    chk("t4_press2_clean", clean_h, 4'b0000);
    chk("t4_press2_pulse", press_h, 4'b0100);
    raw = 4'b0000; step(6);
    chk("t4_rel2_pulse", rel_h, 4'b0100);
    raw = 4'b0100; step(6);
    raw = 4'b0000; step(6);
    chk("t4_latched", clean_h, 4'b0100);
    tog = 4'b0000; #1;
    chk("t4_drop_toggle", clean_h, 4'b0000);
    step(2);

    // 5: reset mid-debounce on bit 3
    raw = 4'b1000; step(4);
    chk("t5_pre_reset", press_h | clean_h, 4'b0000);
    reset = 1'b1; step(1);
    reset = 1'b0;
    step(5);
    chk("t5_e5_clean", clean_h, 4'b0000);
    step(1);
    chk("t5_e6_clean", clean_h, 4'b1000);
    chk("t5_e6_press", press_h, 4'b1000);
    raw = 4'b0000; step(8);

    // 6: simultaneous edges, both input polarities
    raw = 4'b1010; step(6);
    chk("t6_press_hi", press_h, 4'b1010);
    chk("t6_clean_hi", clean_h, 4'b1010);
    chk("t6_press_lo", press_l, 4'b1010);
    chk("t6_clean_lo", clean_l, 4'b1010);
    raw = 4'b0000; step(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
